// File: rtl/uart_rx_os.sv
// 8N1-style UART receiver driven by an oversampling clock enable (sample_tick).
// Define UART_RX_PARITY_EN to insert a parity bit between the data bits and the stop bit.
module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 framing_error,
  output logic                 parity_error,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF     = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] LAST     = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("uart_rx_os: DATA_BITS must be 5..9");
  end
  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
    $error("uart_rx_os: OVERSAMPLE must be even and >= 4");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
    $error("uart_rx_os: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK_WAIT
  } state_t;

  state_t               state, state_n;
  logic [CW-1:0]        tick_cnt, cnt_n;
  logic [IW-1:0]        bit_idx, idx_n;
  logic [DATA_BITS-1:0] sr, sr_n;
  logic                 rx_m, rx_s;
  logic                 done;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit, par_n;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    cnt_n   = tick_cnt;
    idx_n   = bit_idx;
    sr_n    = sr;
    done    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_n   = par_bit;
`endif
    if (sample_tick) begin
      case (state)
        IDLE: if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
        // Half a bit into the start bit: a line that is high again was a glitch.
        START: if (tick_cnt == HALF) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end else cnt_n = tick_cnt + 1'b1;
        DATA: if (tick_cnt == LAST) begin
          sr_n  = {rx_s, sr[DATA_BITS-1:1]};
          cnt_n = '0;
          if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else idx_n = bit_idx + 1'b1;
        end else cnt_n = tick_cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
        PARITY: if (tick_cnt == LAST) begin
          par_n   = rx_s;
          cnt_n   = '0;
          state_n = STOP;
        end else cnt_n = tick_cnt + 1'b1;
`endif
        // A low stop bit parks in BREAK_WAIT so a held-low line gives one frame only.
        STOP: if (tick_cnt == LAST) begin
          done    = 1'b1;
          cnt_n   = '0;
          state_n = rx_s ? IDLE : BREAK_WAIT;
        end else cnt_n = tick_cnt + 1'b1;
        BREAK_WAIT: if (rx_s) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m          <= 1'b1;
      rx_s          <= 1'b1;
      tick_cnt      <= '0;
      bit_idx       <= '0;
      sr            <= '0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      rx_m       <= rx;
      rx_s       <= rx_m;
      tick_cnt   <= cnt_n;
      bit_idx    <= idx_n;
      sr         <= sr_n;
      data_valid <= done;
      if (done) begin
        data_out      <= sr;
        framing_error <= ~rx_s;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_bit      <= 1'b0;
      parity_error <= 1'b0;
    end else begin
      par_bit <= par_n;
      if (done) parity_error <= (^sr) ^ par_bit ^ 1'(PARITY_ODD);
    end
  end
`else
  assign parity_error = 1'b0;
`endif

  assign busy = (state != IDLE);

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Serial UART receiver that consumes the 16x oversampling tick produced by the baud generator and recovers 8N1 frames from the rx line.
- Sits between the pad-side rx input and the byte-level consumer logic; the consumer sees a parallel byte plus a one-cycle valid pulse and error flags.
- Runs entirely in the system clock domain; the tick is a clock enable, not a clock.

Parameters:
- DATA_BITS, 8, number of data bits per frame, LSB first; legal range 5-9.
- OVERSAMPLE, 16, ticks per bit period; must be even and at least 4.
- PARITY_ODD, 0, used only with UART_RX_PARITY_EN; 0 selects even parity, 1 selects odd parity.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- sample_tick  input  1  one-clk-wide enable at baud*OVERSAMPLE rate.
- rx  input  1  asynchronous serial line; idle high.
- data_out  output  DATA_BITS  last received byte; held until the next frame completes.
- data_valid  output  1  one-clk pulse when data_out updates.
- framing_error  output  1  stop bit sampled low on the last frame; held until the next frame completes.
- parity_error  output  1  parity mismatch on the last frame; constant 0 when the macro is undefined.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: one cycle of rst at a clk edge clears everything.
  - Outputs: data_out=0, data_valid=0, framing_error=0, parity_error=0, busy=0.
  - Internal: FSM goes to IDLE, tick counter=0, shift register=0, synchronizer flops=1.
  - Reset mid-frame discards the partial frame; no data_valid is produced for it.
- Input path: rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s, which adds 2 clk of latency.
- tick_cnt is $clog2(OVERSAMPLE) bits wide and advances only on clk edges where sample_tick=1. No state changes except on tick edges, apart from rst and the data_valid clear.
- IDLE:
  - On a tick with rx_s=0: go to START, tick_cnt=0.
- START:
  - Counts ticks. On the tick where tick_cnt == OVERSAMPLE/2-1, sample rx_s.
  - rx_s=0: go to DATA, tick_cnt=0, bit_idx=0.
  - rx_s=1: glitch rejected, go to IDLE, no outputs change.
- DATA:
  - On the tick where tick_cnt == OVERSAMPLE-1, sample rx_s (this is mid-bit).
  - Shift it in LSB first (shift right, new bit into the MSB) and reset tick_cnt.
  - After DATA_BITS samples, go to PARITY if the macro is defined, otherwise to STOP.
- PARITY (macro only): sample at tick_cnt == OVERSAMPLE-1, store the bit, go to STOP.
- STOP: sample at tick_cnt == OVERSAMPLE-1.
  - On the next clk after this sample:
    - data_out <= shift register.
    - data_valid=1 for exactly one clk.
    - framing_error <= ~rx_s.
    - parity_error updates per the optional feature.
  - rx_s=1: go to IDLE.
  - rx_s=0: go to BREAK_WAIT.
- BREAK_WAIT:
  - Stay until a tick sees rx_s=1, then go to IDLE.
  - A held-low line (break) therefore yields exactly one frame plus framing_error, never a stream of frames.
- Frame end: the next start bit may be detected on the first tick after returning to IDLE, so back-to-back frames are accepted with zero idle bits.
- No consumer handshake: an unread data_out is overwritten by the next frame. The consumer must capture it on data_valid.
- sample_tick held low indefinitely: the FSM freezes in its current state with no timeout.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - The PARITY state is inserted after DATA.
  - parity_error <= (XOR of the data bits ^ received parity bit ^ PARITY_ODD) != 0, updated together with data_valid.
- Undefined:
  - The PARITY state does not exist; the frame is start + DATA_BITS + stop.
  - parity_error is tied to 0.

Test Plan:
- Bench setup for all scenarios: OVERSAMPLE=16, sample_tick every 4 clk, so one bit = 64 clk.
- Send 0xA5 as 8N1, stop=1 -> data_out=0xA5, data_valid high for exactly 1 clk, framing_error=0, busy falls after the stop sample.
- Pull rx low for 20 clk, then high -> START rejects the glitch, no data_valid, FSM returns to IDLE.
- Send 0x3C with stop=0, then hold rx low for 300 clk -> one data_valid with data_out=0x3C and framing_error=1, no further frames until rx returns high.
- Send 0x00 then 0xFF back-to-back with no idle bits -> two data_valid pulses, 640 clk apart, with data_out 0x00 then 0xFF and framing_error=0 on both.
- Assert rst for 1 clk during bit 3 of a frame -> all outputs 0 the next cycle, no data_valid for that frame, a following frame 0x55 is received correctly.
- With UART_RX_PARITY_EN and PARITY_ODD=0, send 0x07 with parity bit 0 -> data_out=0x07, parity_error=1; resend with parity bit 1 -> parity_error=0.
